// File: rtl/fpaddsub_align_shift_pipe.sv
// Alignment shifter for the FP add/sub datapath: shifts the smaller significand right and produces guard/round/sticky.
// Define FPADDSUB_ALIGN_DENORM_EN to add a hidden_in port that replaces the constant hidden bit.
module fpaddsub_align_shift_pipe #(
  parameter int MANT_W  = 23,
  parameter int SHIFT_W = 5,
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  mant_in,
`ifdef FPADDSUB_ALIGN_DENORM_EN
  input  logic               hidden_in,
`endif
  input  logic [SHIFT_W-1:0] shift_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W:0]    mmin_out,
  output logic               guard_out,
  output logic               round_out,
  output logic               sticky_out
);

  localparam int W = MANT_W + 3;

  logic               hid;
  logic [W-1:0]       ext;
  logic [SHIFT_W-1:0] coarse;
  logic               sat_in;
  logic [W-1:0]       c_data;
  logic               c_sticky;

`ifdef FPADDSUB_ALIGN_DENORM_EN
  assign hid = hidden_in;
`else
  assign hid = 1'b1;
`endif

  assign ext    = {hid, mant_in, 2'b00};
  assign coarse = {shift_in[SHIFT_W-1:2], 2'b00};
  assign sat_in = 32'(shift_in) >= 32'(W);

  // Saturated beats are reduced to zero data here, with every significand bit folded into sticky.
  always_comb begin
    c_data   = ext >> coarse;
    c_sticky = |(ext & ~({W{1'b1}} << coarse));
    if (sat_in) begin
      c_data   = '0;
      c_sticky = |ext;
    end
  end

  logic         rdy_q;
  logic         out_adv;
  logic         mid_valid;
  logic [W-1:0] p_data;
  logic         p_sticky;
  logic [1:0]   p_fine;
  logic         p_sat;

  assign out_adv = !out_valid || out_ready;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_q <= 1'b0;
    else      rdy_q <= 1'b1;
  end

  generate
    if (STAGES == 2) begin : g_two
      logic s1_valid;

      assign in_ready  = rdy_q && (!s1_valid || out_adv);
      assign mid_valid = s1_valid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_valid <= 1'b0;
          p_data   <= '0;
          p_sticky <= 1'b0;
          p_fine   <= 2'b00;
          p_sat    <= 1'b0;
        end else if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            p_data   <= c_data;
            p_sticky <= c_sticky;
            p_fine   <= shift_in[1:0];
            p_sat    <= sat_in;
          end
        end
      end
    end else begin : g_one
      assign in_ready  = rdy_q && out_adv;
      assign mid_valid = in_valid && in_ready;
      assign p_data    = c_data;
      assign p_sticky  = c_sticky;
      assign p_fine    = shift_in[1:0];
      assign p_sat     = sat_in;
    end
  endgenerate

  logic [W-1:0] f_data;
  logic         f_sticky;

  always_comb begin
    f_data   = p_data >> p_fine;
    f_sticky = p_sticky | (|(p_data & ~({W{1'b1}} << p_fine)));
    if (p_sat) begin
      f_data   = '0;
      f_sticky = p_sticky;
    end
  end

  // Output data only changes on a load, so it stays put while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      mmin_out   <= '0;
      guard_out  <= 1'b0;
      round_out  <= 1'b0;
      sticky_out <= 1'b0;
    end else if (out_adv) begin
      out_valid <= mid_valid;
      if (mid_valid) begin
        mmin_out   <= f_data[W-1:2];
        guard_out  <= f_data[1];
        round_out  <= f_data[0];
        sticky_out <= f_sticky;
      end
    end
  end

endmodule

// File: tb/tb_fpaddsub_align_shift_pipe.sv
// Self-checking bench for fpaddsub_align_shift_pipe: directed cases plus random traffic against an arithmetic model.
module tb_fpaddsub_align_shift_pipe;
  localparam int MANT_W  = 23;
  localparam int SHIFT_W = 5;
  localparam int STAGES  = 2;
  localparam int W       = MANT_W + 3;
  localparam int RW      = MANT_W + 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [MANT_W-1:0]  mant_in;
  logic               hidden_in;
  logic [SHIFT_W-1:0] shift_in;
  logic               out_valid;
  logic               out_ready;
  logic [MANT_W:0]    mmin_out;
  logic               guard_out;
  logic               round_out;
  logic               sticky_out;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  bit live = 0;
  bit stalled = 0;
  bit last_in_fire = 0;
  int nout = 0;

  fpaddsub_align_shift_pipe #(.MANT_W(MANT_W), .SHIFT_W(SHIFT_W), .STAGES(STAGES)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mant_in(mant_in),
`ifdef FPADDSUB_ALIGN_DENORM_EN
    .hidden_in(hidden_in),
`endif
    .shift_in(shift_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mmin_out(mmin_out),
    .guard_out(guard_out),
    .round_out(round_out),
    .sticky_out(sticky_out)
  );

  always #5 clk = ~clk;

  // Reference: shift the extended significand as a plain integer.
  function automatic logic [RW-1:0] model(input logic h, input logic [MANT_W-1:0] m, input int sh);
    logic [63:0] e, s;
    logic st;
    e = (64'(h) << (MANT_W + 2)) | (64'(m) << 2);
    if (sh >= W) begin
      s  = 64'd0;
      st = (e != 64'd0);
    end else begin
      s  = e >> sh;
      st = (e & ((64'd1 << sh) - 64'd1)) != 64'd0;
    end
    return {s[W-1:0], st};
  endfunction

  function automatic logic hid_eff();
`ifdef FPADDSUB_ALIGN_DENORM_EN
    return hidden_in;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (stalled) chk("hold_valid", 64'(out_valid), 64'd1);
    if (live) chk("in_ready", 64'(in_ready), 64'((exp_q.size() < STAGES) || out_ready));
    if (out_valid) begin
      chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        chk("result", 64'({mmin_out, guard_out, round_out, sticky_out}), 64'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          nout++;
        end
      end
    end
    stalled = out_valid && !out_ready;
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) exp_q.push_back(model(hid_eff(), mant_in, int'(shift_in)));
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string tag, input logic h, input logic [MANT_W-1:0] m,
                            input int sh, input logic [RW-1:0] expv);
    hidden_in = h;
    mant_in   = m;
    shift_in  = SHIFT_W'(sh);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk({tag, "_accept"}, 64'(last_in_fire), 64'd1);
    in_valid = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      chk({tag, "_early"}, 64'(out_valid), 64'd0);
      tick();
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk(tag, 64'({mmin_out, guard_out, round_out, sticky_out}), 64'(expv));
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    int n0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    hidden_in = 1'b1;
    shift_in  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'({mmin_out, guard_out, round_out, sticky_out}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("post_release_in_ready", 64'(in_ready), 64'd1);
    live = 1;

    // Directed cases
    run_single("zero_shift", 1'b1, 23'h000000, 0,  {24'h800000, 1'b0, 1'b0, 1'b0});
    run_single("shift4",     1'b1, 23'h00000F, 4,  {24'h080000, 1'b1, 1'b1, 1'b1});
    run_single("shift24",    1'b1, 23'h000000, 24, {24'h000000, 1'b1, 1'b0, 1'b0});
    run_single("shift25",    1'b1, 23'h000000, 25, {24'h000000, 1'b0, 1'b1, 1'b0});
    run_single("sat26",      1'b1, 23'h000000, 26, {24'h000000, 1'b0, 1'b0, 1'b1});
    run_single("sat31",      1'b1, 23'h000000, 31, {24'h000000, 1'b0, 1'b0, 1'b1});
`ifdef FPADDSUB_ALIGN_DENORM_EN
    run_single("denorm1",    1'b0, 23'h400000, 1,  {24'h200000, 1'b0, 1'b0, 1'b0});
    run_single("denorm_sat", 1'b0, 23'h000000, 31, {24'h000000, 1'b0, 1'b0, 1'b0});
`endif

    // Six-beat stream with a three-cycle output stall
    sent = 0;
    cyc  = 0;
    n0   = nout;
    hidden_in = 1'b1;
    while (sent < 6 && cyc < 40) begin
      in_valid  = 1'b1;
      shift_in  = SHIFT_W'(sent);
      mant_in   = MANT_W'($urandom);
      out_ready = !(cyc >= 2 && cyc < 5);
      #1;
      if (cyc >= 2 && cyc < 5) chk("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
      if (last_in_fire) sent++;
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'd6);
    drain();
    chk("stream_count", 64'(nout - n0), 64'd6);

    // Reset with two beats in flight
    in_valid  = 1'b1;
    out_ready = 1'b0;
    mant_in   = 23'h123456;
    shift_in  = 5'd3;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'({mmin_out, guard_out, round_out, sticky_out}), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    live    = 0;
    stalled = 0;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_release_in_ready", 64'(in_ready), 64'd0);
    tick();
    live = 1;
    for (int k = 0; k < 5; k++) begin
      chk("no_stale_beat", 64'(out_valid), 64'd0);
      tick();
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mant_in   = ($urandom_range(0, 7) == 0) ? '0 : MANT_W'($urandom);
      shift_in  = SHIFT_W'($urandom_range(0, 31));
`ifdef FPADDSUB_ALIGN_DENORM_EN
      hidden_in = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
